// File: rtl/mmult_seq_pkg.sv
// Shared definitions for the MMULT sequencer: FSM state encoding, the
// smallest legal matrix width and default datapath sizes.
package mmult_seq_pkg;

  // Default matrix word-address width (byte address bits 23:2).
  localparam int ADDR_W_DEF = 22;

  // Default multiply/accumulate latency from last issue to valid result.
  localparam int PIPE_LAT_DEF = 2;

  // Narrowest matrix the systolic unit can process.
  localparam logic [3:0] MWIDTH_MIN = 4'd3;

  // Sequencer states.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // True when a launch with this width may proceed.
  function automatic logic width_legal(input logic [3:0] w);
    return (w >= MWIDTH_MIN);
  endfunction

endpackage

// File: rtl/mmult_addr_step.sv
// Matrix address walker: holds the current word address, loads the base on
// launch and advances by one word (row order) or by the matrix width
// (column order) on every issued element. Arithmetic wraps silently.
module mmult_addr_step
  import mmult_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic              step_i,
  input  logic              col_mode_i,
  input  logic [3:0]        width_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] stride;

  // Column mode jumps a whole row of words, row mode walks consecutive words.
  always_comb begin
    stride = col_mode_i ? ADDR_W'(width_i) : ADDR_W'(1);
  end

  // Load has priority over stepping; the sum truncates to ADDR_W bits.
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = base_i;
    end else if (step_i) begin
      addr_d = addr_q + stride;
    end
  end

  // Address register, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/mmult_seq.sv
// MMULT sequencer. Accepts a launch from decode, loads and steps the
// register-half counter, walks the matrix address, waits out the
// multiply/accumulate pipeline and holds the result write until the
// register file acknowledges it. All control outputs are registered; mr1
// and maddr come straight from their holding registers.
module mmult_seq
  import mmult_seq_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        mwidth,
  input  logic              maddw,
  input  logic [ADDR_W-1:0] mtxa,
  input  logic [4:0]        rs_base,
  input  logic              stall,
  input  logic              wr_ack,
  output logic              cntld,
  output logic              cnten,
  output logic [4:0]        mr1,
  output logic [ADDR_W-1:0] maddr,
  output logic              mac_en,
  output logic              mac_clr,
  output logic              wr_req,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Drain counter only needs to hold PIPE_LAT-1.
  localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_e             state_q;
  state_e             state_d;
  logic [3:0]         remain_q;
  logic [3:0]         remain_d;
  logic               first_q;
  logic               first_d;
  logic [DRAIN_W-1:0] drain_q;
  logic [DRAIN_W-1:0] drain_d;
  logic               armed_q;
  logic               armed_d;

  logic [3:0]         mwidth_q;
  logic               maddw_q;
  logic [4:0]         mr1_q;

  logic               cntld_q;
  logic               cntld_d;
  logic               cnten_q;
  logic               cnten_d;
  logic               mac_clr_q;
  logic               mac_clr_d;
  logic               wr_req_q;
  logic               wr_req_d;
  logic               busy_q;
  logic               busy_d;
  logic               done_q;
  logic               done_d;
  logic               err_q;
  logic               err_d;

  logic               accept;
  logic               issue_now;

  // A launch is taken only from IDLE and only with a legal width.
  always_comb begin
    accept = (state_q == S_IDLE) && start && width_legal(mwidth);
  end

  // An element is being issued in this cycle whenever the registered step
  // enable is up while in RUN; this drives both address and remain updates.
  always_comb begin
    issue_now = (state_q == S_RUN) && cnten_q;
  end

  // Next-state logic plus the registered outputs for the following cycle.
  // Outputs are derived from the next state so they line up with it; the
  // stall seen this cycle gates the issue slot of the next cycle.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    first_d  = first_q;
    drain_d  = drain_q;
    armed_d  = armed_q;
    err_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (width_legal(mwidth)) begin
            state_d  = S_LOAD;
            remain_d = mwidth;
            first_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (issue_now) begin
          remain_d = remain_q - 4'd1;
          first_d  = 1'b0;
          if (remain_q == 4'd1) begin
            state_d = S_DRAIN;
            drain_d = DRAIN_W'(PIPE_LAT - 1);
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          state_d = S_WRITE;
          armed_d = 1'b0;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      S_WRITE: begin
        // An ack in the very cycle the request first appears cannot be a
        // reply to it, so acks count from the second WRITE cycle on.
        armed_d = 1'b1;
        if (armed_q && wr_ack) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cntld_d   = (state_d == S_LOAD);
    cnten_d   = (state_d == S_RUN) && !stall;
    mac_clr_d = cnten_d && first_d;
    wr_req_d  = (state_d == S_WRITE);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  // FSM and sequencing counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      remain_q <= '0;
      first_q  <= 1'b0;
      drain_q  <= '0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      first_q  <= first_d;
      drain_q  <= drain_d;
      armed_q  <= armed_d;
    end
  end

  // Launch parameters captured when a start is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mwidth_q <= '0;
      maddw_q  <= 1'b0;
      mr1_q    <= '0;
    end else if (accept) begin
      mwidth_q <= mwidth;
      maddw_q  <= maddw;
      mr1_q    <= rs_base;
    end
  end

  // Registered control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cntld_q   <= 1'b0;
      cnten_q   <= 1'b0;
      mac_clr_q <= 1'b0;
      wr_req_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cntld_q   <= cntld_d;
      cnten_q   <= cnten_d;
      mac_clr_q <= mac_clr_d;
      wr_req_q  <= wr_req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  mmult_addr_step #(
    .ADDR_W (ADDR_W)
  ) u_addr (
    .clk        (clk),
    .reset      (reset),
    .load_i     (accept),
    .base_i     (mtxa),
    .step_i     (issue_now),
    .col_mode_i (maddw_q),
    .width_i    (mwidth_q),
    .addr_o     (maddr)
  );

  assign cntld   = cntld_q;
  assign cnten   = cnten_q;
  assign mac_en  = cnten_q;
  assign mac_clr = mac_clr_q;
  assign wr_req  = wr_req_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign mr1     = mr1_q;

endmodule

// File: tb/tb_mmult_seq.sv
// Bench for the MMULT sequencer: directed scenarios with literal
// expectations plus a randomized run, all cross-checked every cycle against
// a timeline model of the launch.
module tb_mmult_seq;

  localparam int ADDR_W   = 22;
  localparam int PIPE_LAT = 2;
  localparam int LOGN     = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [3:0]        mwidth;
  logic              maddw;
  logic [ADDR_W-1:0] mtxa;
  logic [4:0]        rs_base;
  logic              stall;
  logic              wr_ack;
  logic              cntld;
  logic              cnten;
  logic [4:0]        mr1;
  logic [ADDR_W-1:0] maddr;
  logic              mac_en;
  logic              mac_clr;
  logic              wr_req;
  logic              busy;
  logic              done;
  logic              err;

  int errors = 0;
  int checks = 0;

  mmult_seq #(
    .ADDR_W   (ADDR_W),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mwidth  (mwidth),
    .maddw   (maddw),
    .mtxa    (mtxa),
    .rs_base (rs_base),
    .stall   (stall),
    .wr_ack  (wr_ack),
    .cntld   (cntld),
    .cnten   (cnten),
    .mr1     (mr1),
    .maddr   (maddr),
    .mac_en  (mac_en),
    .mac_clr (mac_clr),
    .wr_req  (wr_req),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Timeline model: a launch is described by its age in cycles, the number
  // of elements issued, the cycle of the last issue and the cycle of the
  // counted ack. Expected outputs for the next cycle follow from those.
  bit          mActive = 1'b0;
  bit          modelReady = 1'b0;
  int          mAge = 0;
  int          mNeed = 0;
  int          mIssued = 0;
  int          mLast = -1;
  int          mAck = -1;
  logic [21:0] mBase = '0;
  logic [21:0] mStep = '0;
  logic [4:0]  mRs = '0;
  bit          eCntld = 0, eIssue = 0, eClr = 0, eWr = 0, eBusy = 0, eDone = 0, eErr = 0;
  logic [21:0] eMaddr = '0;
  logic [4:0]  eMr1 = '0;

  always @(posedge clk or posedge reset) begin
    int n;
    int wstart;
    if (reset) begin
      mActive = 1'b0;
      {eCntld, eIssue, eClr, eWr, eBusy, eDone, eErr} = '0;
    end else begin
      eErr = 1'b0;
      if (mActive) begin
        if (eIssue) begin
          mIssued++;
          if (mIssued == mNeed) mLast = mAge;
        end
        if (mLast >= 0) begin
          wstart = mLast + PIPE_LAT + 1;
          if (mAck < 0 && mAge >= wstart + 1 && wr_ack) mAck = mAge;
        end
        if (mAck >= 0 && mAge >= mAck + 1) mActive = 1'b0;
      end else if (start) begin
        if (mwidth >= 4'd3) begin
          mActive = 1'b1;
          mAge    = 0;
          mNeed   = int'(mwidth);
          mIssued = 0;
          mLast   = -1;
          mAck    = -1;
          mBase   = mtxa;
          mStep   = maddw ? 22'(mwidth) : 22'd1;
          mRs     = rs_base;
        end else begin
          eErr = 1'b1;
        end
      end
      if (mActive) begin
        n      = mAge + 1;
        wstart = mLast + PIPE_LAT + 1;
        eCntld = (n == 1);
        eIssue = (n >= 2) && (mIssued < mNeed) && !stall;
        eClr   = eIssue && (mIssued == 0);
        eWr    = (mLast >= 0) && (n >= wstart) && (mAck < 0);
        eDone  = (mAck >= 0) && (n == mAck + 1);
        eBusy  = 1'b1;
        eMaddr = mBase + 22'(mIssued) * mStep;
        eMr1   = mRs;
        mAge   = n;
      end else begin
        {eCntld, eIssue, eClr, eWr, eBusy, eDone} = '0;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (modelReady) begin
      checks++;
      if ({cntld, cnten, mac_en, mac_clr, wr_req, busy, done, err} !==
          {eCntld, eIssue, eIssue, eClr, eWr, eBusy, eDone, eErr}) begin
        errors++;
        $display("[TB] FAIL model_flags t=%0t: got %b expected %b (cntld,cnten,mac_en,mac_clr,wr_req,busy,done,err)",
                 $time, {cntld, cnten, mac_en, mac_clr, wr_req, busy, done, err},
                 {eCntld, eIssue, eIssue, eClr, eWr, eBusy, eDone, eErr});
      end
      if (eIssue) begin
        checks++;
        if (maddr !== eMaddr) begin
          errors++;
          $display("[TB] FAIL model_maddr t=%0t: got %h expected %h", $time, maddr, eMaddr);
        end
      end
      if (eCntld) begin
        checks++;
        if (mr1 !== eMr1) begin
          errors++;
          $display("[TB] FAIL model_mr1 t=%0t: got %h expected %h", $time, mr1, eMr1);
        end
      end
    end
  end

  // Per-cycle capture for the directed scenarios.
  typedef struct packed {
    logic        cntld;
    logic        cnten;
    logic        mac_clr;
    logic        wr_req;
    logic        busy;
    logic        done;
    logic        err;
    logic [4:0]  mr1;
    logic [21:0] maddr;
  } obs_t;

  obs_t logA[LOGN];
  bit   startSeq[LOGN];
  bit   stallSeq[LOGN];
  bit   ackSeq[LOGN];
  bit   rstSeq[LOGN];

  task automatic clearStim();
    for (int k = 0; k < LOGN; k++) begin
      startSeq[k] = 1'b0;
      stallSeq[k] = 1'b0;
      ackSeq[k]   = 1'b1;
      rstSeq[k]   = 1'b0;
    end
  endtask

  // Cycle k: capture outputs of cycle k, then drive inputs sampled at its end.
  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      logA[k] = {cntld, cnten, mac_clr, wr_req, busy, done, err, mr1, maddr};
      #1;
      start  = startSeq[k];
      stall  = stallSeq[k];
      wr_ack = ackSeq[k];
      reset  = rstSeq[k];
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setLaunch(input logic [3:0] w, input logic col, input logic [21:0] base, input logic [4:0] rs);
    mwidth  = w;
    maddw   = col;
    mtxa    = base;
    rs_base = rs;
  endtask

  function automatic int countCnten(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) if (logA[k].cnten) c++;
    return c;
  endfunction

  function automatic int countDone(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) if (logA[k].done) c++;
    return c;
  endfunction

  function automatic int countWr(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) if (logA[k].wr_req) c++;
    return c;
  endfunction

  initial begin
    logic [21:0] issueAddr[8];
    int          ni;

    reset = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    wr_ack = 1'b0;
    setLaunch(4'd0, 1'b0, 22'd0, 5'd0);
    repeat (3) @(negedge clk);
    checkOutput("reset_flags", {25'd0, cntld, cnten, mac_en, mac_clr, wr_req, busy, done}, 32'd0);
    checkOutput("reset_err", {31'd0, err}, 32'd0);
    checkOutput("reset_maddr", {10'd0, maddr}, 32'd0);
    checkOutput("reset_mr1", {27'd0, mr1}, 32'd0);
    #1;
    reset = 1'b0;
    modelReady = 1'b1;

    // Row mode, no stalls, ack held high.
    clearStim();
    setLaunch(4'd3, 1'b0, 22'h100, 5'd4);
    startSeq[0] = 1'b1;
    applyStimulus(12);
    checkOutput("row_cntld_c1", {31'd0, logA[1].cntld}, 32'd1);
    checkOutput("row_mr1_c1", {27'd0, logA[1].mr1}, 32'd4);
    checkOutput("row_maddr_c1", {10'd0, logA[1].maddr}, 32'h100);
    checkOutput("row_clr_c2", {31'd0, logA[2].mac_clr}, 32'd1);
    checkOutput("row_maddr_c2", {10'd0, logA[2].maddr}, 32'h100);
    checkOutput("row_clr_c3", {31'd0, logA[3].mac_clr}, 32'd0);
    checkOutput("row_maddr_c3", {10'd0, logA[3].maddr}, 32'h101);
    checkOutput("row_maddr_c4", {10'd0, logA[4].maddr}, 32'h102);
    checkOutput("row_issue_count", countCnten(12), 32'd3);
    checkOutput("row_wrreq_c7", {31'd0, logA[7].wr_req}, 32'd1);
    checkOutput("row_done_c8", {31'd0, logA[8].done}, 32'd0);
    checkOutput("row_done_c9", {31'd0, logA[9].done}, 32'd1);
    checkOutput("row_busy_c10", {31'd0, logA[10].busy}, 32'd0);

    // Column mode with a three-cycle stall over the second issue slot.
    clearStim();
    setLaunch(4'd4, 1'b1, 22'h10, 5'd9);
    startSeq[0] = 1'b1;
    stallSeq[2] = 1'b1;
    stallSeq[3] = 1'b1;
    stallSeq[4] = 1'b1;
    applyStimulus(16);
    ni = 0;
    for (int k = 0; k < 16; k++) begin
      if (logA[k].cnten && ni < 8) begin
        issueAddr[ni] = logA[k].maddr;
        ni++;
      end
    end
    checkOutput("col_issue_count", ni, 32'd4);
    checkOutput("col_maddr0", {10'd0, issueAddr[0]}, 32'h10);
    checkOutput("col_maddr1", {10'd0, issueAddr[1]}, 32'h14);
    checkOutput("col_maddr2", {10'd0, issueAddr[2]}, 32'h18);
    checkOutput("col_maddr3", {10'd0, issueAddr[3]}, 32'h1C);
    checkOutput("col_done_c13", {31'd0, logA[13].done}, 32'd1);
    checkOutput("col_done_count", countDone(16), 32'd1);

    // Address wrap at the top of the word space.
    clearStim();
    setLaunch(4'd4, 1'b0, 22'h3FFFFE, 5'd1);
    startSeq[0] = 1'b1;
    applyStimulus(12);
    checkOutput("wrap_maddr_c2", {10'd0, logA[2].maddr}, 32'h3FFFFE);
    checkOutput("wrap_maddr_c3", {10'd0, logA[3].maddr}, 32'h3FFFFF);
    checkOutput("wrap_maddr_c4", {10'd0, logA[4].maddr}, 32'h000000);
    checkOutput("wrap_maddr_c5", {10'd0, logA[5].maddr}, 32'h000001);

    // Illegal width.
    clearStim();
    setLaunch(4'd2, 1'b0, 22'h40, 5'd2);
    startSeq[0] = 1'b1;
    applyStimulus(4);
    checkOutput("illegal_err_c1", {31'd0, logA[1].err}, 32'd1);
    checkOutput("illegal_busy_c1", {31'd0, logA[1].busy}, 32'd0);
    checkOutput("illegal_err_c2", {31'd0, logA[2].err}, 32'd0);

    // Starts while busy are dropped.
    clearStim();
    setLaunch(4'd5, 1'b0, 22'h80, 5'd3);
    startSeq[0] = 1'b1;
    startSeq[3] = 1'b1;
    startSeq[4] = 1'b1;
    applyStimulus(20);
    checkOutput("busy_start_done_c11", {31'd0, logA[11].done}, 32'd1);
    checkOutput("busy_start_done_count", countDone(20), 32'd1);

    // Write backpressure: ack low for the first ten request cycles.
    clearStim();
    setLaunch(4'd3, 1'b0, 22'h200, 5'd6);
    startSeq[0] = 1'b1;
    for (int k = 0; k < 17; k++) ackSeq[k] = 1'b0;
    applyStimulus(24);
    checkOutput("bp_wrreq_cycles", countWr(24), 32'd11);
    checkOutput("bp_done_c18", {31'd0, logA[18].done}, 32'd1);
    checkOutput("bp_done_count", countDone(24), 32'd1);

    // Reset at the second issue, then a clean relaunch.
    clearStim();
    setLaunch(4'd4, 1'b0, 22'h200, 5'd7);
    startSeq[0] = 1'b1;
    rstSeq[3] = 1'b1;
    applyStimulus(6);
    checkOutput("rst_issue_c3", {31'd0, logA[3].cnten}, 32'd1);
    checkOutput("rst_maddr_c3", {10'd0, logA[3].maddr}, 32'h201);
    checkOutput("rst_flags_c4", {25'd0, logA[4].cntld, logA[4].cnten, logA[4].mac_clr,
                                 logA[4].wr_req, logA[4].busy, logA[4].done, logA[4].err}, 32'd0);
    checkOutput("rst_maddr_c4", {10'd0, logA[4].maddr}, 32'd0);
    checkOutput("rst_mr1_c4", {27'd0, logA[4].mr1}, 32'd0);
    clearStim();
    setLaunch(4'd3, 1'b0, 22'h300, 5'd5);
    startSeq[0] = 1'b1;
    applyStimulus(12);
    checkOutput("relaunch_mr1_c1", {27'd0, logA[1].mr1}, 32'd5);
    checkOutput("relaunch_maddr_c2", {10'd0, logA[2].maddr}, 32'h300);
    checkOutput("relaunch_done_c9", {31'd0, logA[9].done}, 32'd1);

    // Randomized traffic checked by the model alone.
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      #1;
      start   = ($urandom_range(0, 5) == 0);
      mwidth  = 4'($urandom_range(0, 15));
      maddw   = 1'($urandom_range(0, 1));
      mtxa    = 22'($urandom);
      rs_base = 5'($urandom_range(0, 31));
      stall   = ($urandom_range(0, 3) == 0);
      wr_ack  = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    wr_ack = 1'b1;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
